// File: rtl/croc_bank_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM bank among NumMgr OBI managers.
// Optional conflict counter is built only when CROC_BANK_ARB_CONFLICT_CNT_EN is defined.
module croc_bank_arbiter #(
  parameter int NumMgr    = 4,
  parameter int NumWords  = 512,
  parameter int DataWidth = 32,
  parameter int IdWidth   = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumMgr-1:0]                 mgr_req_i,
  input  logic [NumMgr*32-1:0]              mgr_addr_i,
  input  logic [NumMgr-1:0]                 mgr_we_i,
  input  logic [NumMgr*(DataWidth/8)-1:0]   mgr_be_i,
  input  logic [NumMgr*DataWidth-1:0]       mgr_wdata_i,
  input  logic [NumMgr*IdWidth-1:0]         mgr_aid_i,
  output logic [NumMgr-1:0]                 mgr_gnt_o,
  output logic [NumMgr-1:0]                 mgr_rvalid_o,
  output logic [DataWidth-1:0]              mgr_rdata_o,
  output logic [IdWidth-1:0]                mgr_rid_o,
  output logic                              mgr_err_o,
  output logic                              sram_req_o,
  output logic                              sram_we_o,
  output logic [$clog2(NumWords)-1:0]       sram_addr_o,
  output logic [DataWidth/8-1:0]            sram_be_o,
  output logic [DataWidth-1:0]              sram_wdata_o,
  input  logic [DataWidth-1:0]              sram_rdata_i,
  input  logic                              cnt_clr_i,
  output logic [31:0]                       conflict_cnt_o
);

  localparam int AW = $clog2(NumWords);
  localparam int PW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  localparam int BW = DataWidth / 8;

  // Handshake: a manager holds req with stable attributes until it sees gnt in
  // the same cycle; exactly one rvalid follows each gnt one cycle later.
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      win_idx;
  logic               win_valid;
  logic [PW:0]        scan_idx;
  logic               win_we;
  logic [IdWidth-1:0] win_aid;

  logic               rsp_pending;
  logic [PW-1:0]      rsp_idx;
  logic               rsp_we;
  logic [IdWidth-1:0] rsp_id;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NumMgr; i++) begin
      scan_idx = {1'b0, ptr} + (PW+1)'(i);
      if (scan_idx >= (PW+1)'(NumMgr)) scan_idx = scan_idx - (PW+1)'(NumMgr);
      if (!win_valid && mgr_req_i[scan_idx[PW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    win_we       = 1'b0;
    win_aid      = '0;
    sram_addr_o  = '0;
    sram_be_o    = '0;
    sram_wdata_o = '0;
    mgr_gnt_o    = '0;
    for (int i = 0; i < NumMgr; i++) begin
      if (win_idx == PW'(i)) begin
        win_we       = mgr_we_i[i];
        win_aid      = mgr_aid_i[i*IdWidth +: IdWidth];
        sram_addr_o  = mgr_addr_i[i*32+2 +: AW];
        sram_be_o    = mgr_be_i[i*BW +: BW];
        sram_wdata_o = mgr_wdata_i[i*DataWidth +: DataWidth];
        mgr_gnt_o[i] = win_valid && !rst_i;
      end
    end
  end

  assign sram_req_o = win_valid && !rst_i;
  assign sram_we_o  = win_we;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr         <= '0;
      rsp_pending <= 1'b0;
      rsp_idx     <= '0;
      rsp_we      <= 1'b0;
      rsp_id      <= '0;
    end else begin
      rsp_pending <= win_valid;
      if (win_valid) begin
        ptr     <= (win_idx == PW'(NumMgr-1)) ? '0 : win_idx + PW'(1);
        rsp_idx <= win_idx;
        rsp_we  <= win_we;
        rsp_id  <= win_aid;
      end
    end
  end

  always_comb begin
    mgr_rvalid_o = '0;
    for (int i = 0; i < NumMgr; i++) begin
      mgr_rvalid_o[i] = rsp_pending && (rsp_idx == PW'(i));
    end
  end

  // Writes still produce a response, but carry zero data.
  assign mgr_rdata_o = (rsp_pending && !rsp_we) ? sram_rdata_i : '0;
  assign mgr_rid_o   = rsp_id;
  assign mgr_err_o   = 1'b0;

`ifdef CROC_BANK_ARB_CONFLICT_CNT_EN
  logic [31:0] conflict_cnt;
  logic [3:0]  req_pop;

  always_comb begin
    req_pop = '0;
    for (int i = 0; i < NumMgr; i++) begin
      req_pop = req_pop + 4'(mgr_req_i[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conflict_cnt <= '0;
    end else if (cnt_clr_i) begin
      conflict_cnt <= '0;
    end else if (req_pop >= 4'd2 && conflict_cnt != 32'hFFFF_FFFF) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt;
`else
  assign conflict_cnt_o = '0;
`endif

  // Upper address bits and the byte offset are deliberately ignored.
  logic addr_unused;
  assign addr_unused = ^{mgr_addr_i, cnt_clr_i};

endmodule

// File: tb/tb_croc_bank_arbiter.sv
// Bench for croc_bank_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a behavioural round-robin/SRAM model.
module tb_croc_bank_arbiter;

  localparam int N  = 4;
  localparam int NW = 512;
  localparam int DW = 32;
  localparam int IW = 1;
  localparam int AW = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    mgr_req;
  logic [N*32-1:0] mgr_addr;
  logic [N-1:0]    mgr_we;
  logic [N*4-1:0]  mgr_be;
  logic [N*DW-1:0] mgr_wdata;
  logic [N*IW-1:0] mgr_aid;
  logic [N-1:0]    mgr_gnt;
  logic [N-1:0]    mgr_rvalid;
  logic [DW-1:0]   mgr_rdata;
  logic [IW-1:0]   mgr_rid;
  logic            mgr_err;
  logic            sram_req;
  logic            sram_we;
  logic [AW-1:0]   sram_addr;
  logic [3:0]      sram_be;
  logic [DW-1:0]   sram_wdata;
  logic [DW-1:0]   sram_rdata;
  logic            cnt_clr;
  logic [31:0]     conflict_cnt;

  int n_checks = 0;
  int n_errors = 0;

  croc_bank_arbiter #(.NumMgr(N), .NumWords(NW), .DataWidth(DW), .IdWidth(IW)) dut (
    .clk_i(clk), .rst_i(rst),
    .mgr_req_i(mgr_req), .mgr_addr_i(mgr_addr), .mgr_we_i(mgr_we), .mgr_be_i(mgr_be),
    .mgr_wdata_i(mgr_wdata), .mgr_aid_i(mgr_aid),
    .mgr_gnt_o(mgr_gnt), .mgr_rvalid_o(mgr_rvalid), .mgr_rdata_o(mgr_rdata),
    .mgr_rid_o(mgr_rid), .mgr_err_o(mgr_err),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_be_o(sram_be), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
    .cnt_clr_i(cnt_clr), .conflict_cnt_o(conflict_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- SRAM environment (tc_sram behaviour) ----------------
  logic [DW-1:0] mem [NW];
  initial begin
    for (int i = 0; i < NW; i++) mem[i] = '0;
    sram_rdata = '0;
  end
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++) if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_ptr;
  bit            m_pend;
  int            m_idx;
  bit            m_we;
  logic [IW-1:0] m_id;
  logic [DW-1:0] m_rd;
  logic [31:0]   m_cnt;
  logic [DW-1:0] shadow [NW];
  initial for (int i = 0; i < NW; i++) shadow[i] = '0;

  always @(negedge clk) begin
    int w;
    int word;
    logic [31:0] a;
    logic [3:0] be;
    logic [31:0] exp_cnt;
    if (rst) begin
      m_ptr = 0; m_pend = 0; m_idx = 0; m_we = 0; m_id = '0; m_cnt = '0;
      check("rst_gnt", mgr_gnt, 0);
      check("rst_sram_req", sram_req, 0);
      check("rst_rvalid", mgr_rvalid, 0);
      check("rst_rdata", mgr_rdata, 0);
      check("rst_rid", mgr_rid, 0);
      check("rst_err", mgr_err, 0);
      check("rst_cnt", conflict_cnt, 0);
    end else begin
      w = -1;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (w < 0 && mgr_req[k]) w = k;
      end
      check("gnt", mgr_gnt, (w >= 0) ? (32'd1 << w) : 32'd0);
      check("sram_req", sram_req, (w >= 0) ? 1 : 0);
      if (w >= 0) begin
        a    = mgr_addr[w*32 +: 32];
        word = (a / 4) % NW;
        be   = mgr_be[w*4 +: 4];
        check("sram_addr", sram_addr, word);
        check("sram_we", sram_we, mgr_we[w]);
        check("sram_be", sram_be, be);
        check("sram_wdata", sram_wdata, mgr_wdata[w*DW +: DW]);
      end
      check("rvalid", mgr_rvalid, m_pend ? (32'd1 << m_idx) : 32'd0);
      if (m_pend) begin
        check("rid", mgr_rid, m_id);
        check("rdata", mgr_rdata, m_we ? 32'd0 : m_rd);
      end
      check("err", mgr_err, 0);
`ifdef CROC_BANK_ARB_CONFLICT_CNT_EN
      exp_cnt = m_cnt;
`else
      exp_cnt = 0;
`endif
      check("conflict_cnt", conflict_cnt, exp_cnt);
      // advance model across the coming edge
      m_pend = (w >= 0);
      if (w >= 0) begin
        m_idx = w;
        m_we  = mgr_we[w];
        m_id  = mgr_aid[w*IW +: IW];
        m_ptr = (w + 1) % N;
        if (mgr_we[w]) begin
          for (int b = 0; b < 4; b++) if (be[b]) shadow[word][8*b +: 8] = mgr_wdata[w*DW + 8*b +: 8];
        end else begin
          m_rd = shadow[word];
        end
      end
      if (cnt_clr) m_cnt = 0;
      else if ($countones(mgr_req) >= 2 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    mgr_req = '0; mgr_addr = '0; mgr_we = '0; mgr_be = '0; mgr_wdata = '0; mgr_aid = '0;
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wdata, input logic [IW-1:0] aid);
    mgr_req[i]             = 1'b1;
    mgr_addr[i*32 +: 32]   = addr;
    mgr_we[i]              = we;
    mgr_be[i*4 +: 4]       = be;
    mgr_wdata[i*DW +: DW]  = wdata;
    mgr_aid[i*IW +: IW]    = aid;
  endtask

  // Leaves the bench in the first post-reset cycle, inputs idle.
  task automatic do_reset();
    tick();
    rst = 1'b1;
    clear_reqs();
    set_req(2, 32'h0, 1'b0, 4'hF, 32'h0, 1'b0);
    at_neg();
    check("lit_rst_gnt_gated", mgr_gnt, 4'b0000);
    tick();
    rst = 1'b0;
    clear_reqs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] cnt_exp5;
    rst = 1'b1;
    cnt_clr = 1'b0;
    clear_reqs();
    repeat (3) at_neg();
    check("lit_reset_rvalid", mgr_rvalid, 4'b0000);
    check("lit_reset_sram_req", sram_req, 1'b0);

    // single write then read by mgr1
    tick();
    rst = 1'b0;
    set_req(1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0);
    at_neg();
    check("lit_t1_wr_gnt", mgr_gnt, 4'b0010);
    tick();
    clear_reqs();
    set_req(1, 32'h10, 1'b0, 4'hF, 32'h0, 1'b1);
    at_neg();
    check("lit_t1_rd_gnt", mgr_gnt, 4'b0010);
    check("lit_t1_wr_rvalid", mgr_rvalid, 4'b0010);
    check("lit_t1_wr_rdata", mgr_rdata, 32'h0);
    tick();
    clear_reqs();
    at_neg();
    check("lit_t1_rd_rvalid", mgr_rvalid, 4'b0010);
    check("lit_t1_rd_rdata", mgr_rdata, 32'hDEADBEEF);
    check("lit_t1_rd_rid", mgr_rid, 1);

    // round robin with all four requesting
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'h100 + 4*i, 1'b0, 4'hF, 32'h0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      at_neg();
      check("lit_rr_gnt", mgr_gnt, 32'd1 << (c % 4));
      if (c > 0) check("lit_rr_rvalid", mgr_rvalid, 32'd1 << ((c - 1) % 4));
      tick();
    end
    clear_reqs();
    at_neg();
    check("lit_rr_last_rvalid", mgr_rvalid, 4'b1000);

    // pointer skip: make ptr=1, then mgr0 and mgr3 compete
    tick();
    set_req(0, 32'h20, 1'b0, 4'hF, 32'h0, 1'b0);
    at_neg();
    check("lit_skip_pre_gnt", mgr_gnt, 4'b0001);
    tick();
    set_req(3, 32'h24, 1'b0, 4'hF, 32'h0, 1'b1);
    at_neg();
    check("lit_skip_gnt3", mgr_gnt, 4'b1000);
    tick();
    mgr_req[3] = 1'b0;
    at_neg();
    check("lit_skip_gnt0", mgr_gnt, 4'b0001);
    check("lit_skip_rvalid3", mgr_rvalid, 4'b1000);

    // byte enables
    tick();
    clear_reqs();
    set_req(2, 32'h40, 1'b1, 4'hF, 32'hAAAAAAAA, 1'b0);
    at_neg();
    tick();
    set_req(2, 32'h40, 1'b1, 4'h3, 32'h11223344, 1'b0);
    at_neg();
    tick();
    set_req(2, 32'h40, 1'b0, 4'hF, 32'h0, 1'b0);
    at_neg();
    tick();
    clear_reqs();
    at_neg();
    check("lit_be_rvalid", mgr_rvalid, 4'b0100);
    check("lit_be_rdata", mgr_rdata, 32'hAAAA3344);

    // reset in the cycle after a grant
    tick();
    set_req(3, 32'h40, 1'b0, 4'hF, 32'h0, 1'b1);
    at_neg();
    check("lit_rm_gnt", mgr_gnt, 4'b1000);
    tick();
    clear_reqs();
    rst = 1'b1;
    set_req(1, 32'h44, 1'b0, 4'hF, 32'h0, 1'b0);
    set_req(3, 32'h48, 1'b0, 4'hF, 32'h0, 1'b0);
    at_neg();
    check("lit_rm_rvalid_dropped", mgr_rvalid, 4'b0000);
    check("lit_rm_gnt_gated", mgr_gnt, 4'b0000);
    tick();
    rst = 1'b0;
    at_neg();
    check("lit_rm_first_gnt", mgr_gnt, 4'b0010);
    check("lit_rm_no_rvalid", mgr_rvalid, 4'b0000);

    // conflict counter
    tick();
    clear_reqs();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      clear_reqs();
      set_req(c % 4, 32'h50, 1'b0, 4'hF, 32'h0, 1'b0);
      set_req((c + 1) % 4, 32'h54, 1'b0, 4'hF, 32'h0, 1'b0);
      at_neg();
      tick();
    end
    clear_reqs();
    at_neg();
`ifdef CROC_BANK_ARB_CONFLICT_CNT_EN
    cnt_exp5 = 32'd5;
`else
    cnt_exp5 = 32'd0;
`endif
    check("lit_cnt_five", conflict_cnt, cnt_exp5);
    tick();
    for (int i = 0; i < N; i++) set_req(i, 32'h60, 1'b0, 4'hF, 32'h0, 1'b0);
    cnt_clr = 1'b1;
    at_neg();
    tick();
    cnt_clr = 1'b0;
    clear_reqs();
    at_neg();
    check("lit_cnt_cleared", conflict_cnt, 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst     = ($urandom_range(0, 199) == 0);
      cnt_clr = ($urandom_range(0, 49) == 0);
      clear_reqs();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 99) < 55) begin
          logic [31:0] a;
          a = ($urandom() & 32'hFFFF_F800) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
          set_req(i, a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
                  IW'($urandom_range(0, 1)));
        end
      end
    end
    tick();
    rst = 1'b0;
    cnt_clr = 1'b0;
    clear_reqs();
    repeat (2) at_neg();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
